// File: rtl/input_port_pkg.sv
// Shared types and field layout for the input port packetiser.
// INPUT_PORT_CSUM_EN adds an XOR checksum tail flit to every packet.
package input_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2,
      ST_TAIL = 2'd3
   } state_t;

   localparam int LEN_W = 8;

   // Head-flit field offsets, measured downward from the flit MSB
   localparam int HDR_OFS = 0;

   function automatic int addr_ofs(input int hdr_w);
      return hdr_w;
   endfunction

   function automatic int len_ofs(input int hdr_w, input int addr_w);
      return hdr_w + addr_w;
   endfunction

   function automatic int nflit(input int data_w, input int flit_w);
`ifdef INPUT_PORT_CSUM_EN
      return data_w / flit_w + 2;
`else
      return data_w / flit_w + 1;
`endif
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// First-word-fall-through flit buffer; dout reads zero while empty.
// Pointers wrap explicitly so non power-of-two depths also work.
module flit_fifo #(
   parameter int FLIT_W     = 64,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [FLIT_W-1:0]             din,
   output logic                          full,
   input  logic                          pop,
   output logic [FLIT_W-1:0]             dout,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);

   logic [FLIT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/input_port_param.sv
// Packetiser: captures a granted header/address/payload and streams head,
// body (and with INPUT_PORT_CSUM_EN a checksum tail) flits into a FWFT FIFO.
module input_port_param
   import input_port_pkg::*;
#(
   parameter int DATA_W     = 1024,
   parameter int FLIT_W     = 64,
   parameter int HDR_W      = 9,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          arbiter_gnt,
   input  logic [HDR_W-1:0]              header_pkt_send,
   input  logic [ADDR_W-1:0]             dst_addr_arbiter_send,
   input  logic [DATA_W-1:0]             data_arbiter_send,
   output logic                          ready_encap_dfx,
   input  logic                          rd_en,
   output logic [FLIT_W-1:0]             dout,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int NBEAT    = DATA_W / FLIT_W;
   localparam int NFLIT    = nflit(DATA_W, FLIT_W);
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int BEAT_W   = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam int HDR_MSB  = FLIT_W - 1 - HDR_OFS;
   localparam int ADDR_MSB = FLIT_W - 1 - addr_ofs(HDR_W);
   localparam int LEN_MSB  = FLIT_W - 1 - len_ofs(HDR_W, ADDR_W);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

   state_t              state, state_nxt;
   logic [HDR_W-1:0]    hdr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   pay_q;
   logic [BEAT_W-1:0]   beat;
   logic [FLIT_W-1:0]   head_flit, push_data;
   logic [CNT_W-1:0]    free;
   logic                push, full, accept, body_push;
`ifdef INPUT_PORT_CSUM_EN
   logic [FLIT_W-1:0]   csum_q;
`endif

   // rst_n gating keeps ready low for the whole reset window
   assign free            = CNT_W'(FIFO_DEPTH) - fifo_count;
   assign ready_encap_dfx = rst_n && (state == ST_IDLE) && (free >= CNT_W'(NFLIT));
   assign accept          = arbiter_gnt && ready_encap_dfx;
   assign body_push       = (state == ST_BODY) && !full;

   always_comb begin
      head_flit = '0;
      head_flit[HDR_MSB  -: HDR_W]  = hdr_q;
      head_flit[ADDR_MSB -: ADDR_W] = addr_q;
      head_flit[LEN_MSB  -: LEN_W]  = LEN_W'(NFLIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_data = '0;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_HEAD;
         ST_HEAD: begin
            push      = 1'b1;
            push_data = head_flit;
            if (!full) state_nxt = ST_BODY;
         end
         ST_BODY: begin
            push      = 1'b1;
            push_data = pay_q[DATA_W-1 -: FLIT_W];
`ifdef INPUT_PORT_CSUM_EN
            if (!full && beat == LAST_BEAT) state_nxt = ST_TAIL;
`else
            if (!full && beat == LAST_BEAT) state_nxt = ST_IDLE;
`endif
         end
`ifdef INPUT_PORT_CSUM_EN
         ST_TAIL: begin
            push      = 1'b1;
            push_data = csum_q;
            if (!full) state_nxt = ST_IDLE;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         beat <= '0;
      else if (accept)    beat <= '0;
      else if (body_push) beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
   end

   // Payload shifts left so the next beat always sits at the top
   always_ff @(posedge clk) begin
      if (accept) begin
         hdr_q  <= header_pkt_send;
         addr_q <= dst_addr_arbiter_send;
         pay_q  <= data_arbiter_send;
`ifdef INPUT_PORT_CSUM_EN
         csum_q <= '0;
`endif
      end else if (body_push) begin
         pay_q  <= pay_q << FLIT_W;
`ifdef INPUT_PORT_CSUM_EN
         csum_q <= csum_q ^ pay_q[DATA_W-1 -: FLIT_W];
`endif
      end
   end

   flit_fifo #(
      .FLIT_W     (FLIT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_data),
      .full  (full),
      .pop   (rd_en),
      .dout  (dout),
      .empty (empty),
      .count (fifo_count)
   );

endmodule
